// File: rtl/dc_tag_pkg.sv
// Shared types and constants for the data-cache tag miss controller:
// tag-entry layout, MESI encodings, RRIP constants and controller states.
package dc_tag_pkg;

    localparam int DC_WAYS    = 8;
    localparam int DC_ENTRY_W = 24;

    localparam logic [2:0] MESI_I = 3'd0;
    localparam logic [2:0] MESI_S = 3'd1;
    localparam logic [2:0] MESI_E = 3'd2;
    localparam logic [2:0] MESI_M = 3'd3;

    localparam logic [1:0] RRIP_INSERT  = 2'd2;
    localparam logic [1:0] RRIP_DISTANT = 2'd3;

    localparam logic [2:0] SC_CMD_REQ_S = 3'd1;
    localparam logic [2:0] SC_CMD_REQ_M = 3'd2;

    typedef struct packed {
        logic [2:0]  state;
        logic [1:0]  rrip;
        logic        rsvd;
        logic [17:0] tag;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_PICK,
        ST_AGE,
        ST_FILL,
        ST_ACK
    } state_t;

    function automatic entry_t age_entry(input entry_t e);
        entry_t r;
        r = e;
        if (e.rrip != RRIP_DISTANT) r.rrip = e.rrip + 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/dc_victim_pick.sv
// Combinational victim choice over one set: lowest invalid way first,
// then lowest way at distant RRIP; found=0 means the set must be aged.
module dc_victim_pick
    import dc_tag_pkg::*;
(
    input  logic [DC_WAYS*DC_ENTRY_W-1:0] entries,
    output logic                          found,
    output logic [2:0]                    way
);

    entry_t     e;
    logic       inv_found;
    logic       dist_found;
    logic [2:0] inv_way;
    logic [2:0] dist_way;

    always_comb begin
        e          = '0;
        inv_found  = 1'b0;
        dist_found = 1'b0;
        inv_way    = 3'd0;
        dist_way   = 3'd0;
        // Walk downward so the last match written is the lowest way.
        for (int i = DC_WAYS - 1; i >= 0; i--) begin
            e = entry_t'(entries[i*DC_ENTRY_W +: DC_ENTRY_W]);
            if (e.state == MESI_I) begin
                inv_found = 1'b1;
                inv_way   = 3'(i);
            end
            if (e.rrip == RRIP_DISTANT) begin
                dist_found = 1'b1;
                dist_way   = 3'(i);
            end
        end
        found = inv_found | dist_found;
        way   = inv_found ? inv_way : dist_way;
    end

endmodule

// File: rtl/dc_tag_miss_ctrl.sv
// Tag-bank miss controller: scans a set, picks/ages an RRIP victim, fills it.
// Optional tag-hit promotion is enabled by defining DC_HIT_PROMOTE_EN.
module dc_tag_miss_ctrl
    import dc_tag_pkg::*;
#(
    parameter int WAYS     = 8,
    parameter int SET_BITS = 5,
    parameter int TAG_BITS = 18,
    parameter int ENTRY_W  = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_retry,
    input  logic [SET_BITS-1:0] req_set,
    input  logic [TAG_BITS-1:0] req_tag,
    input  logic                req_store,
    output logic                tb_rd_en,
    output logic [SET_BITS-1:0] tb_rd_set,
    output logic [2:0]          tb_rd_way,
    input  logic [ENTRY_W-1:0]  tb_rd_data,
    output logic                tb_wr_en,
    output logic [SET_BITS-1:0] tb_wr_set,
    output logic [2:0]          tb_wr_way,
    output logic [ENTRY_W-1:0]  tb_wr_data,
    output logic                ack_valid,
    input  logic                ack_retry,
    output logic [2:0]          ack_way,
    output logic                ack_hit,
    output logic                ack_wb,
    output logic [2:0]          ack_cmd
);

    state_t                state, state_nxt;
    logic [2:0]            idx, idx_nxt;
    entry_t [WAYS-1:0]     ent_buf;
    logic [SET_BITS-1:0]   req_set_q;
    logic [TAG_BITS-1:0]   req_tag_q;
    logic                  req_store_q;
    logic [2:0]            way_q;
    logic                  hit_q;
    logic                  wb_q;
    logic                  pick_found;
    logic [2:0]            pick_way;
    logic                  hit;
    logic [2:0]            hit_way;
    entry_t                fill_entry;

    dc_victim_pick u_pick (
        .entries (ent_buf),
        .found   (pick_found),
        .way     (pick_way)
    );

`ifdef DC_HIT_PROMOTE_EN
    always_comb begin
        hit     = 1'b0;
        hit_way = 3'd0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (ent_buf[i].state != MESI_I && ent_buf[i].tag == req_tag_q) begin
                hit     = 1'b1;
                hit_way = 3'(i);
            end
        end
    end
    assign ack_hit = (state == ST_ACK) ? hit_q : 1'b0;
`else
    assign hit     = 1'b0;
    assign hit_way = 3'd0;
    assign ack_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= 3'd0;
            ent_buf     <= '0;
            req_set_q   <= '0;
            req_tag_q   <= '0;
            req_store_q <= 1'b0;
            way_q       <= 3'd0;
            hit_q       <= 1'b0;
            wb_q        <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_set_q   <= req_set;
                        req_tag_q   <= req_tag;
                        req_store_q <= req_store;
                    end
                end
                // Read data trails its strobe by one cycle.
                ST_SCAN:  if (idx != 3'd0) ent_buf[idx - 3'd1] <= entry_t'(tb_rd_data);
                ST_DRAIN: ent_buf[WAYS-1] <= entry_t'(tb_rd_data);
                ST_PICK: begin
                    way_q <= hit ? hit_way : pick_way;
                    hit_q <= hit;
                    wb_q  <= !hit && (ent_buf[pick_way].state == MESI_M);
                end
                ST_AGE:  ent_buf[idx] <= age_entry(ent_buf[idx]);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        tb_rd_en   = 1'b0;
        tb_rd_set  = '0;
        tb_rd_way  = 3'd0;
        tb_wr_en   = 1'b0;
        tb_wr_set  = '0;
        tb_wr_way  = 3'd0;
        tb_wr_data = '0;
        fill_entry = ent_buf[way_q];
        if (hit_q) begin
            fill_entry.rrip = 2'd0;
        end else begin
            fill_entry.state = req_store_q ? MESI_M : MESI_S;
            fill_entry.rrip  = RRIP_INSERT;
            fill_entry.rsvd  = 1'b0;
            fill_entry.tag   = 18'(req_tag_q);
        end
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = ST_SCAN;
                    idx_nxt   = 3'd0;
                end
            end
            ST_SCAN: begin
                tb_rd_en  = 1'b1;
                tb_rd_set = req_set_q;
                tb_rd_way = idx;
                idx_nxt   = idx + 3'd1;
                if (idx == 3'd7) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = ST_PICK;
            ST_PICK: begin
                idx_nxt   = 3'd0;
                state_nxt = (hit || pick_found) ? ST_FILL : ST_AGE;
            end
            ST_AGE: begin
                tb_wr_en   = 1'b1;
                tb_wr_set  = req_set_q;
                tb_wr_way  = idx;
                tb_wr_data = ENTRY_W'(age_entry(ent_buf[idx]));
                idx_nxt    = idx + 3'd1;
                if (idx == 3'd7) state_nxt = ST_PICK;
            end
            ST_FILL: begin
                tb_wr_en   = 1'b1;
                tb_wr_set  = req_set_q;
                tb_wr_way  = way_q;
                tb_wr_data = ENTRY_W'(fill_entry);
                state_nxt  = ST_ACK;
            end
            ST_ACK:  if (!ack_retry) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign req_retry = (state != ST_IDLE);
    assign ack_valid = (state == ST_ACK);
    assign ack_way   = ack_valid ? way_q : 3'd0;
    assign ack_wb    = ack_valid ? wb_q : 1'b0;
    assign ack_cmd   = (!ack_valid || hit_q) ? 3'd0 :
                       (req_store_q ? SC_CMD_REQ_M : SC_CMD_REQ_S);

endmodule

// File: tb/tb_dc_tag_miss_ctrl.sv
// Randomized self-checking bench for dc_tag_miss_ctrl with a tag-bank model
// and a rule-level reference for victim choice, ageing, fill and latency.
module tb_dc_tag_miss_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_retry, req_store;
    logic [4:0]  req_set;
    logic [17:0] req_tag;
    logic        tb_rd_en, tb_wr_en;
    logic [4:0]  tb_rd_set, tb_wr_set;
    logic [2:0]  tb_rd_way, tb_wr_way;
    logic [23:0] tb_rd_data, tb_wr_data;
    logic        ack_valid, ack_retry, ack_hit, ack_wb;
    logic [2:0]  ack_way, ack_cmd;

    always #5 clk = ~clk;

    dc_tag_miss_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_retry  (req_retry),
        .req_set    (req_set),
        .req_tag    (req_tag),
        .req_store  (req_store),
        .tb_rd_en   (tb_rd_en),
        .tb_rd_set  (tb_rd_set),
        .tb_rd_way  (tb_rd_way),
        .tb_rd_data (tb_rd_data),
        .tb_wr_en   (tb_wr_en),
        .tb_wr_set  (tb_wr_set),
        .tb_wr_way  (tb_wr_way),
        .tb_wr_data (tb_wr_data),
        .ack_valid  (ack_valid),
        .ack_retry  (ack_retry),
        .ack_way    (ack_way),
        .ack_hit    (ack_hit),
        .ack_wb     (ack_wb),
        .ack_cmd    (ack_cmd)
    );

    int n_chk = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int strobe_bad = 0;

    logic [23:0] mem [32][8];
    logic        ld_en = 1'b0;
    logic [4:0]  ld_set = 5'd0;
    logic [23:0] ld_data [8];
    logic [23:0] m_set [8];

    int          exp_way, exp_lat, exp_writes;
    logic        exp_hit, exp_wb;
    logic [2:0]  exp_cmd;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Tag bank: one-cycle read latency, write on the strobe edge.
    always @(posedge clk) begin
        if (tb_rd_en) begin
            tb_rd_data <= mem[tb_rd_set][tb_rd_way];
            rd_cnt     <= rd_cnt + 1;
        end
        if (tb_wr_en) begin
            mem[tb_wr_set][tb_wr_way] <= tb_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (ld_en) for (int w = 0; w < 8; w++) mem[ld_set][w] <= ld_data[w];
    end

    always @(negedge clk) begin
        if (tb_rd_en && tb_wr_en) strobe_bad++;
        if (!tb_rd_en && (tb_rd_set != 0 || tb_rd_way != 0)) strobe_bad++;
        if (!tb_wr_en && (tb_wr_set != 0 || tb_wr_way != 0 || tb_wr_data != 0)) strobe_bad++;
    end

    function automatic logic [23:0] mk(input int st, input int rr, input int tg);
        logic [2:0]  s;
        logic [1:0]  r;
        logic [17:0] t;
        s = 3'(st);
        r = 2'(rr);
        t = 18'(tg);
        return {s, r, 1'b0, t};
    endfunction

    // Reference: hit promotion (if built in), else lowest I, else lowest
    // rrip==3, else age the whole set by one and try again.
    task automatic model(input logic [17:0] tag, input logic store);
        int passes;
        int vic;
        exp_hit = 1'b0;
        exp_way = 0;
`ifdef DC_HIT_PROMOTE_EN
        for (int w = 0; w < 8; w++)
            if (!exp_hit && m_set[w][23:21] != 0 && m_set[w][17:0] == tag) begin
                exp_hit = 1'b1;
                exp_way = w;
            end
`endif
        if (exp_hit) begin
            m_set[exp_way][20:19] = 2'd0;
            exp_wb = 1'b0;
            exp_cmd = 3'd0;
            exp_lat = 12;
            exp_writes = 1;
        end else begin
            passes = 0;
            vic = -1;
            while (vic < 0 && passes < 4) begin
                for (int w = 7; w >= 0; w--) if (m_set[w][20:19] == 3) vic = w;
                for (int w = 7; w >= 0; w--) if (m_set[w][23:21] == 0) vic = (vic >= 0 && m_set[vic][23:21] == 0 && vic < w) ? vic : w;
                if (vic < 0) begin
                    for (int w = 0; w < 8; w++)
                        if (m_set[w][20:19] < 3) m_set[w][20:19] = m_set[w][20:19] + 2'd1;
                    passes++;
                end
            end
            exp_way = vic;
            exp_wb = (m_set[vic][23:21] == 3);
            exp_cmd = store ? 3'd2 : 3'd1;
            m_set[vic] = mk(store ? 3 : 1, 2, int'(tag));
            exp_lat = 12 + 9 * passes;
            exp_writes = 8 * passes + 1;
        end
    endtask

    task automatic load(input logic [4:0] s);
        ld_set = s;
        ld_en = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_req(input string nm, input logic [4:0] s, input logic [17:0] tag,
                           input logic store, input int hold);
        int cyc;
        int w0;
        int r0;
        for (int w = 0; w < 8; w++) m_set[w] = mem[s][w];
        model(tag, store);
        w0 = wr_cnt;
        ack_retry = (hold > 0);
        chk({nm, ".idle_retry"}, 32'(req_retry), 0);
        req_valid = 1'b1;
        req_set = s;
        req_tag = tag;
        req_store = store;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!ack_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, ".latency"}, 32'(cyc), 32'(exp_lat));
        chk({nm, ".way"}, 32'(ack_way), 32'(exp_way));
        chk({nm, ".hit"}, 32'(ack_hit), 32'(exp_hit));
        chk({nm, ".wb"}, 32'(ack_wb), 32'(exp_wb));
        chk({nm, ".cmd"}, 32'(ack_cmd), 32'(exp_cmd));
        chk({nm, ".writes"}, 32'(wr_cnt - w0), 32'(exp_writes));
        for (int k = 0; k < hold; k++) begin
            req_valid = (k == 1);
            @(negedge clk);
            chk({nm, ".hold_valid"}, 32'(ack_valid), 1);
            chk({nm, ".hold_way"}, 32'(ack_way), 32'(exp_way));
            chk({nm, ".hold_cmd"}, 32'(ack_cmd), 32'(exp_cmd));
            chk({nm, ".hold_retry"}, 32'(req_retry), 1);
        end
        req_valid = 1'b0;
        ack_retry = 1'b0;
        r0 = rd_cnt;
        @(negedge clk);
        chk({nm, ".ack_done"}, 32'(ack_valid), 0);
        @(negedge clk);
        @(negedge clk);
        chk({nm, ".no_new_req"}, 32'(rd_cnt - r0), 0);
        for (int w = 0; w < 8; w++) chk({nm, ".mem"}, 32'(mem[s][w]), 32'(m_set[w]));
    endtask

    initial begin
        logic [23:0] orig;
        int cyc;
        int w0;
        int r0;
        reset = 1'b0;
        req_valid = 1'b0;
        req_set = '0;
        req_tag = '0;
        req_store = 1'b0;
        ack_retry = 1'b0;
        for (int w = 0; w < 8; w++) ld_data[w] = '0;
        for (int s = 0; s < 32; s++) for (int w = 0; w < 8; w++) mem[s][w] = '0;
        repeat (3) @(negedge clk);
        chk("rst.retry", 32'(req_retry), 0);
        chk("rst.ack_valid", 32'(ack_valid), 0);
        chk("rst.strobes", 32'({tb_rd_en, tb_wr_en}), 0);
        chk("rst.wr_data", 32'(tb_wr_data), 0);
        reset = 1'b1;
        @(negedge clk);

        // All invalid, load -> way 0 filled S/insert.
        for (int w = 0; w < 8; w++) ld_data[w] = '0;
        load(5'd3);
        run_req("all_inv", 5'd3, 18'h1234, 1'b0, 0);

        // Way 5 modified at distant RRIP, store.
        for (int w = 0; w < 8; w++) ld_data[w] = mk(1, 1, 'h200 + w);
        ld_data[5] = mk(3, 3, 'h205);
        load(5'd7);
        run_req("dirty_victim", 5'd7, 18'h3abc, 1'b1, 0);

        // Everything at rrip 1 -> two ageing passes.
        for (int w = 0; w < 8; w++) ld_data[w] = mk(2, 1, 'h300 + w);
        load(5'd12);
        run_req("two_age", 5'd12, 18'h0777, 1'b0, 0);

        // Tag resident in way 6: promoted when built in, a miss otherwise.
        for (int w = 0; w < 8; w++) ld_data[w] = mk(1, 1, 'h400 + w);
        ld_data[6] = mk(2, 2, 'h2aaaa);
        load(5'd20);
        run_req("resident_tag", 5'd20, 18'h2aaaa, 1'b0, 0);

        // Consumer stall for five cycles with a request pulsed during ACK.
        for (int w = 0; w < 8; w++) ld_data[w] = mk(3, 2, 'h500 + w);
        ld_data[2] = mk(0, 0, 'h0);
        load(5'd31);
        run_req("stall", 5'd31, 18'h0055, 1'b1, 5);

        for (int t = 0; t < 40; t++) begin
            logic [4:0] s;
            for (int w = 0; w < 8; w++) begin
                int st;
                int rr;
                st = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3));
                rr = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
                ld_data[w] = mk(st, rr, 'h100 + int'($urandom_range(0, 7)));
                ld_data[w][18] = 1'($urandom_range(0, 1));
            end
            s = 5'($urandom_range(0, 31));
            load(s);
            run_req("rand", s, 18'(18'h100 + 18'($urandom_range(0, 9))),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of an ageing pass.
        for (int w = 0; w < 8; w++) ld_data[w] = mk(1, 1, 'h600 + w);
        load(5'd9);
        orig = mem[9][7];
        req_valid = 1'b1;
        req_set = 5'd9;
        req_tag = 18'h0999;
        req_store = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (cyc < 13) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_age.in_age", 32'(tb_wr_en), 1);
        reset = 1'b0;
        #1;
        chk("mid_age.wr_en", 32'(tb_wr_en), 0);
        chk("mid_age.retry", 32'(req_retry), 0);
        chk("mid_age.ack", 32'(ack_valid), 0);
        w0 = wr_cnt;
        r0 = rd_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_age.no_writes", 32'(wr_cnt - w0), 0);
        chk("mid_age.no_reads", 32'(rd_cnt - r0), 0);
        chk("mid_age.way7_untouched", 32'(mem[9][7]), 32'(orig));
        chk("mid_age.idle_retry", 32'(req_retry), 0);

        chk("strobe_rules", 32'(strobe_bad), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
